// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between CH stream producers, the stream_mux_rr arbiter and
// the single shared consumer.
//   master : drives mode/sel, the input channels and out_ready (producer/consumer side)
//   slave  : the multiplexer itself
// Signals:
//   mode, sel           selection control (0 = fixed via sel, 1 = round-robin)
//   in_valid, in_data   CH channels, channel i data in bits [i*WIDTH +: WIDTH]
//   in_ready            per-channel accept, combinational
//   out_valid/out_ready registered output handshake
//   out_data, out_ch    output beat and the channel it came from
interface stream_mux_rr_if #(
   parameter int WIDTH = 4,
   parameter int CH    = 4
);
   localparam int SELW = $clog2(CH);

   logic                  mode;
   logic [SELW-1:0]       sel;
   logic [CH-1:0]         in_valid;
   logic [CH*WIDTH-1:0]   in_data;
   logic [CH-1:0]         in_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_data;
   logic [SELW-1:0]       out_ch;

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: CH-channel to 1 stream multiplexer with a registered output.
// Fixed selection (mode=0, channel = sel) or round-robin arbitration (mode=1).
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   beat_cnt  16-bit count of output transfers (only when MUX_BEAT_CNT_EN is defined)
//   bus       stream_mux_rr_if.slave: mode, sel, in_valid, in_data, in_ready,
//             out_valid, out_ready, out_data, out_ch
// Optional feature macro: MUX_BEAT_CNT_EN (beat counter port and register).
module stream_mux_rr #(
   parameter int WIDTH = 4,
   parameter int CH    = 4
) (
   input  logic          clk,
   input  logic          rst,
`ifdef MUX_BEAT_CNT_EN
   output logic [15:0]   beat_cnt,
`endif
   stream_mux_rr_if.slave bus
);
   localparam int SELW = $clog2(CH);

   logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_ch_q, out_ch_d;

   logic             accept;
   logic             in_xfer;
   logic             out_xfer;
   logic             grant_vld;
   logic [SELW-1:0]  grant;
   logic [SELW-1:0]  cand;
   logic [CH-1:0]    in_ready;

   assign accept   = !out_valid_q || bus.out_ready;
   assign out_xfer = out_valid_q && bus.out_ready;
   assign in_xfer  = accept && grant_vld && !rst;

   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      cand      = '0;
      if (!bus.mode) begin
         // sel values at or beyond CH match no channel, so they never grant
         for (int i = 0; i < CH; i++) begin
            if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
               grant_vld = 1'b1;
               grant     = SELW'(i);
            end
         end
      end else begin
         // Scan from furthest to nearest so the last hit, i.e. the first valid
         // channel after rr_ptr, is the one that sticks.
         for (int k = CH; k >= 1; k--) begin
            cand = SELW'((int'(rr_ptr_q) + k) % CH);
            if (bus.in_valid[cand]) begin
               grant_vld = 1'b1;
               grant     = cand;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (in_xfer) begin
         in_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      rr_ptr_d    = rr_ptr_q;
      if (in_xfer) begin
         out_valid_d = 1'b1;
         out_ch_d    = grant;
         for (int i = 0; i < CH; i++) begin
            if (grant == SELW'(i)) begin
               out_data_d = bus.in_data[i*WIDTH +: WIDTH];
            end
         end
         if (bus.mode) begin
            rr_ptr_d = grant;
         end
      end else if (out_xfer) begin
         out_valid_d = 1'b0;
      end
   end

   // rr_ptr resets to the last channel so the first round-robin grant is ch0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= SELW'(CH - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
      end
   end

`ifdef MUX_BEAT_CNT_EN
   logic [15:0] beat_cnt_q, beat_cnt_d;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (out_xfer) begin
         beat_cnt_d = beat_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_q <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign beat_cnt = beat_cnt_q;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;
   localparam int WIDTH = 4;
   localparam int CH    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stream_mux_rr_if #(.WIDTH(WIDTH), .CH(CH)) bus ();

`ifdef MUX_BEAT_CNT_EN
   logic [15:0] beat_cnt;
`endif

   stream_mux_rr #(.WIDTH(WIDTH), .CH(CH)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef MUX_BEAT_CNT_EN
      .beat_cnt (beat_cnt),
`endif
      .bus      (bus)
   );

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [5:0] sb_q[$];
   logic [5:0] sb_exp;
   logic [3:0] chd[CH];

   // scoreboard: every output transfer must match the oldest expected beat
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            $display("FAIL sb_unexpected: got data=%h ch=%0d, required no beat", bus.out_data, bus.out_ch);
         end else begin
            sb_exp = sb_q.pop_front();
            if ({bus.out_data, bus.out_ch} !== sb_exp)
               $display("FAIL sb_beat: got data=%h ch=%0d, required data=%h ch=%0d",
                        bus.out_data, bus.out_ch, sb_exp[5:2], sb_exp[1:0]);
            else
               n_pass++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3);
      chd[0] = d0; chd[1] = d1; chd[2] = d2; chd[3] = d3;
      bus.in_data = {d3, d2, d1, d0};
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      sb_q.delete();
      #3;
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      bus.in_valid  = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (sb_q.size() == 0 && !bus.out_valid) break;
         tick();
      end
      n_checks++;
      if (sb_q.size() != 0 || bus.out_valid !== 1'b0)
         $display("FAIL %s_drain: got pending=%0d out_valid=%b, required 0 and 0", name, sb_q.size(), bus.out_valid);
      else
         n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.mode = 1'b1; bus.sel = '0; bus.in_valid = '1; bus.out_ready = 1'b1;
      set_data(4'h3, 4'h5, 4'hA, 4'hD);
      tick(); tick();
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.out_ch} !== 7'd0)
         $display("FAIL reset_out: got v=%b d=%h ch=%0d, required 0 0 0", bus.out_valid, bus.out_data, bus.out_ch);
      else n_pass++;
      n_checks++;
      if (bus.in_ready !== 4'b0000)
         $display("FAIL reset_in_ready: got %b required 0000", bus.in_ready);
      else n_pass++;
      tick();
      rst = 1'b0;
      sb_q.push_back({chd[0], 2'd0});
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 4'b0001)
         $display("FAIL reset_first_grant: got %b required 0001", bus.in_ready);
      else n_pass++;
      tick();
      bus.in_valid = '0;
      drain("reset");
   endtask

   task automatic test_fixed();
      bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
      set_data(4'h3, 4'h5, 4'hA, 4'hD);
      sb_q.push_back({4'hA, 2'd2});
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 4'b0100)
         $display("FAIL fixed_sel2: got %b required 0100", bus.in_ready);
      else n_pass++;
      tick();
      bus.sel = 2'd1;
      sb_q.push_back({4'h5, 2'd1});
      @(negedge clk);
      n_checks++;
      if (bus.out_data !== 4'hA || bus.out_ch !== 2'd2)
         $display("FAIL fixed_out: got d=%h ch=%0d required d=a ch=2", bus.out_data, bus.out_ch);
      else n_pass++;
      n_checks++;
      if (bus.in_ready !== 4'b0010)
         $display("FAIL fixed_sel1: got %b required 0010", bus.in_ready);
      else n_pass++;
      tick();
      // mode=0 grants must not have moved the round-robin pointer (still ch0)
      bus.mode = 1'b1;
      sb_q.push_back({chd[1], 2'd1});
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 4'b0010)
         $display("FAIL rr_ptr_hold: got %b required 0010", bus.in_ready);
      else n_pass++;
      tick();
      bus.mode = 1'b0; bus.sel = 2'd3; bus.in_valid = 4'b0111;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 4'b0000)
         $display("FAIL fixed_sel_invalid: got %b required 0000", bus.in_ready);
      else n_pass++;
      tick();
      drain("fixed");
   endtask

   task automatic test_rr();
      int seq[5] = '{0, 1, 2, 3, 0};
      pulse_reset();
      set_data(4'h1, 4'h2, 4'h4, 4'h8);
      bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) sb_q.push_back({chd[seq[k]], 2'(seq[k])});
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (bus.in_ready !== 4'(1 << seq[k]))
            $display("FAIL rr_grant%0d: got %b required %b", k, bus.in_ready, 4'(1 << seq[k]));
         else n_pass++;
         if (k > 0) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'(seq[k-1]))
               $display("FAIL rr_no_bubble%0d: got v=%b ch=%0d required v=1 ch=%0d", k, bus.out_valid, bus.out_ch, seq[k-1]);
            else n_pass++;
         end
         tick();
      end
      drain("rr");
   endtask

   task automatic test_sparse();
      int seq[4] = '{0, 3, 0, 3};
      pulse_reset();
      set_data(4'h6, 4'h7, 4'h9, 4'hC);
      bus.mode = 1'b1; bus.in_valid = 4'b1001; bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sb_q.push_back({chd[seq[k]], 2'(seq[k])});
         @(negedge clk);
         n_checks++;
         if (bus.in_ready !== 4'(1 << seq[k]))
            $display("FAIL sparse_wrap%0d: got %b required %b", k, bus.in_ready, 4'(1 << seq[k]));
         else n_pass++;
         tick();
      end
      bus.in_valid = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         sb_q.push_back({chd[2], 2'd2});
         @(negedge clk);
         n_checks++;
         if (bus.in_ready !== 4'b0100)
            $display("FAIL sparse_single%0d: got %b required 0100", k, bus.in_ready);
         else n_pass++;
         tick();
      end
      drain("sparse");
   endtask

   task automatic test_backpressure();
      pulse_reset();
      set_data(4'hE, 4'h1, 4'h7, 4'hB);
      bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
      sb_q.push_back({4'hE, 2'd0});
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 4'b0001)
         $display("FAIL bp_first: got %b required 0001", bus.in_ready);
      else n_pass++;
      tick();
      // a mode/sel change during the stall must only steer the next grant
      bus.out_ready = 1'b0; bus.mode = 1'b0; bus.sel = 2'd3;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hE || bus.out_ch !== 2'd0 || bus.in_ready !== 4'b0000)
            $display("FAIL bp_hold%0d: got v=%b d=%h ch=%0d rdy=%b required 1 e 0 0000",
                     k, bus.out_valid, bus.out_data, bus.out_ch, bus.in_ready);
         else n_pass++;
         tick();
      end
      bus.out_ready = 1'b1;
      sb_q.push_back({4'hB, 2'd3});
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 4'b1000)
         $display("FAIL bp_reload: got %b required 1000", bus.in_ready);
      else n_pass++;
      tick();
      bus.in_valid = '0;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3)
         $display("FAIL bp_no_bubble: got v=%b ch=%0d required v=1 ch=3", bus.out_valid, bus.out_ch);
      else n_pass++;
      tick();
      drain("bp");
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      set_data(4'h4, 4'h8, 4'hF, 4'h2);
      bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1)
         $display("FAIL mid_loaded: got %b required 1", bus.out_valid);
      else n_pass++;
      #1;
      rst = 1'b1;
      sb_q.delete();
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000)
         $display("FAIL mid_reset: got v=%b rdy=%b required 0 0000", bus.out_valid, bus.in_ready);
      else n_pass++;
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      sb_q.push_back({chd[0], 2'd0});
      #1;
      n_checks++;
      if (bus.in_ready !== 4'b0001)
         $display("FAIL mid_restart: got %b required 0001", bus.in_ready);
      else n_pass++;
      tick();
      drain("mid");
   endtask

`ifdef MUX_BEAT_CNT_EN
   task automatic test_beat_cnt();
      pulse_reset();
      set_data(4'h9, 4'h1, 4'h2, 4'h3);
      n_checks++;
      if (beat_cnt !== 16'd0) $display("FAIL cnt_reset0: got %0d required 0", beat_cnt);
      else n_pass++;
      bus.mode = 1'b1; bus.in_valid = 4'b0001; bus.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         sb_q.push_back({chd[0], 2'd0});
         tick();
      end
      drain("cnt");
      n_checks++;
      if (beat_cnt !== 16'd10) $display("FAIL cnt_ten: got %0d required 10", beat_cnt);
      else n_pass++;
      pulse_reset();
      n_checks++;
      if (beat_cnt !== 16'd0) $display("FAIL cnt_clear: got %0d required 0", beat_cnt);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_fixed();
      test_rr();
      test_sparse();
      test_backpressure();
      test_reset_mid();
`ifdef MUX_BEAT_CNT_EN
      test_beat_cnt();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
